pwm_monitor: RTL and testbench

Measures the PWM waveform produced by the duty-cycle PWM stage and reports period, high time and duty in tenths (0–10) for status display and self-check. It sits directly downstream of the PWM generator on the same 100 MHz clock, consuming its PWM output. Constant-level outputs (0 % / 100 % duty) are detected by a timeout and reported as stuck-low or stuck-high.

---
 rtl/pwm_monitor.sv | 164 ++++++++++++++++
 tb/tb_pwm_monitor.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pwm_monitor.sv
// pwm_monitor: measures period, high time and duty (tenths) of a PWM input.
// Constant-level inputs are reported as stuck-high/low after TIMEOUT cycles
// without an edge. Duty is computed by a restoring divider that runs
// (10*high_time)/period one subtraction per cycle.
module pwm_monitor #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [3:0]       duty_tenths,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = CNT_W + 4;
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, DIV} state_t;
  state_t r_state, w_state_nxt;

  logic             r_s1, r_s, r_s_d;
  logic             w_rise, w_fall, w_edge;
  logic [CNT_W-1:0] r_per_cnt, r_hi_cnt;
  logic [TW-1:0]    r_tmo_cnt;
  logic [CNT_W-1:0] r_cap_per, r_cap_hi;
  logic [CNT_W-1:0] r_per_w, r_hi_w;
  logic             r_pending;
  logic [AW-1:0]    r_acc, w_per_ext;
  logic [3:0]       r_q;
  logic             w_tmo_fire, w_start, w_div_zero, w_div_done;

  assign w_rise     = r_s & ~r_s_d;
  assign w_fall     = ~r_s & r_s_d;
  assign w_edge     = w_rise | w_fall;
  // Fires on the single cycle the timeout counter steps onto TIMEOUT, so
  // a saturated counter never re-triggers.
  assign w_tmo_fire = (r_tmo_cnt == TMO_LAST) & ~w_edge;
  assign w_start    = (r_state == MEASURE) & r_pending;
  assign w_per_ext  = AW'(r_per_w);
  assign w_div_zero = (r_per_w == '0);
  assign w_div_done = (r_state == DIV) & (w_div_zero | (r_acc < w_per_ext));

  // Two-flop synchroniser plus one history stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s   <= 1'b0;
      r_s_d <= 1'b0;
    end else begin
      r_s1  <= pwm_in;
      r_s   <= r_s1;
      r_s_d <= r_s;
    end
  end

  // Saturating period, high-time and no-edge timeout counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
      r_tmo_cnt <= '0;
    end else begin
      if (w_rise)               r_per_cnt <= CNT_W'(1);
      else if (r_per_cnt != '1) r_per_cnt <= r_per_cnt + CNT_W'(1);

      if (w_rise)                    r_hi_cnt <= CNT_W'(1);
      else if (r_s && r_hi_cnt != '1) r_hi_cnt <= r_hi_cnt + CNT_W'(1);

      if (w_edge)                    r_tmo_cnt <= '0;
      else if (r_tmo_cnt != TMO_MAX) r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end

  // Control FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; timeout overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_rise)     w_state_nxt = MEASURE;
      MEASURE: if (r_pending)  w_state_nxt = DIV;
      DIV:     if (w_div_done) w_state_nxt = MEASURE;
      default:                 w_state_nxt = IDLE;
    endcase
    if (w_tmo_fire) w_state_nxt = IDLE;
  end

  // Capture, divider datapath and registered outputs. Later assignments
  // win, which gives timeout priority over divide completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_per   <= '0;
      r_cap_hi    <= '0;
      r_per_w     <= '0;
      r_hi_w      <= '0;
      r_pending   <= 1'b0;
      r_acc       <= '0;
      r_q         <= '0;
      period      <= '0;
      high_time   <= '0;
      duty_tenths <= '0;
      meas_valid  <= 1'b0;
      stuck_high  <= 1'b0;
      stuck_low   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      // Latest edge wins: a newer capture overwrites one not yet divided.
      if (w_rise && r_state != IDLE) begin
        r_cap_per <= r_per_cnt;
        r_cap_hi  <= r_hi_cnt;
      end

      if (w_tmo_fire)                        r_pending <= 1'b0;
      else if (w_rise && r_state != IDLE)    r_pending <= 1'b1;
      else if (w_start)                      r_pending <= 1'b0;

      if (w_start) begin
        r_acc   <= AW'(r_cap_hi) * AW'(10);
        r_q     <= '0;
        r_per_w <= r_cap_per;
        r_hi_w  <= r_cap_hi;
      end

      if (r_state == DIV) begin
        if (w_div_done) begin
          period      <= r_per_w;
          high_time   <= r_hi_w;
          duty_tenths <= w_div_zero ? 4'd10 : ((r_q > 4'd10) ? 4'd10 : r_q);
          meas_valid  <= 1'b1;
        end else begin
          r_acc <= r_acc - w_per_ext;
          r_q   <= r_q + 4'd1;
        end
      end

      if (w_edge) begin
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
      end

      if (w_tmo_fire) begin
        stuck_high  <= r_s;
        stuck_low   <= ~r_s;
        period      <= '0;
        high_time   <= '0;
        duty_tenths <= r_s ? 4'd10 : 4'd0;
        meas_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_monitor.sv
// Directed bench for pwm_monitor: reset, first edge, duty sweep, fast edges,
// 0 % / 100 % timeouts and async reset during a divide.
module tb_pwm_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm_in;
  logic [15:0] period, high_time;
  logic [3:0]  duty_tenths;
  logic        meas_valid, stuck_high, stuck_low;

  int n_cmp = 0;
  int n_err = 0;
  int n_strobe = 0;
  int last_per = 0, last_hi = 0, last_duty = 0;
  int first_per = -1, first_hi = -1, first_duty = -1;
  int s0;

  pwm_monitor #(.CNT_W(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .period(period), .high_time(high_time), .duty_tenths(duty_tenths),
    .meas_valid(meas_valid), .stuck_high(stuck_high), .stuck_low(stuck_low)
  );

  always #5 clk = ~clk;

  // Strobe recorder, sampled away from the active edge.
  always @(negedge clk) begin
    if (meas_valid) begin
      if (n_strobe == 0) begin
        first_per  <= int'(period);
        first_hi   <= int'(high_time);
        first_duty <= int'(duty_tenths);
      end
      n_strobe  <= n_strobe + 1;
      last_per  <= int'(period);
      last_hi   <= int'(high_time);
      last_duty <= int'(duty_tenths);
    end
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drives cyc cycles of a PWM wave starting at phase 0; call at a negedge.
  task automatic pwm_run(input int per, input int hi, input int cyc);
    for (int i = 0; i < cyc; i++) begin
      pwm_in = ((i % per) < hi);
      @(negedge clk);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    pwm_in = 1'b0;
    wait_cyc(4);
    chk("rst_period",  int'(period), 0);
    chk("rst_high",    int'(high_time), 0);
    chk("rst_duty",    int'(duty_tenths), 0);
    chk("rst_valid",   int'(meas_valid), 0);
    chk("rst_stuck_h", int'(stuck_high), 0);
    chk("rst_stuck_l", int'(stuck_low), 0);
    rst = 1'b0;

    // First rise only arms the measurement; first strobe follows the second.
    pwm_run(10, 5, 15);
    chk("first_no_strobe", n_strobe, 0);
    pwm_run(10, 5, 25);
    chk("first_per",  first_per, 10);
    chk("first_hi",   first_hi, 5);
    chk("first_duty", first_duty, 5);

    // Duty sweep 1..9 of 10.
    for (int h = 1; h <= 9; h++) begin
      pwm_run(10, h, 40);
      chk($sformatf("sweep%0d_per", h),  last_per, 10);
      chk($sformatf("sweep%0d_hi", h),   last_hi, h);
      chk($sformatf("sweep%0d_duty", h), last_duty, h);
    end

    // Edges faster than the divider: 30/4 -> 7.
    s0 = n_strobe;
    pwm_run(4, 3, 80);
    chk("fast_strobes", int'(n_strobe > s0 + 3), 1);
    chk("fast_per",  last_per, 4);
    chk("fast_hi",   last_hi, 3);
    chk("fast_duty", last_duty, 7);

    // 0 % duty: exactly one timeout strobe.
    pwm_in = 1'b0;
    wait_cyc(30);
    s0 = n_strobe;
    chk("low_not_yet", int'(stuck_low), 0);
    wait_cyc(50);
    chk("low_stuck",   int'(stuck_low), 1);
    chk("low_stuck_h", int'(stuck_high), 0);
    chk("low_duty",    int'(duty_tenths), 0);
    chk("low_period",  int'(period), 0);
    chk("low_high",    int'(high_time), 0);
    chk("low_one_strobe", n_strobe, s0 + 1);
    wait_cyc(40);
    chk("low_no_repeat", n_strobe, s0 + 1);

    // Recovery: rise clears the flag, no strobe until a full period.
    s0 = n_strobe;
    pwm_run(10, 5, 10);
    chk("recov_clear",     int'(stuck_low), 0);
    chk("recov_no_strobe", n_strobe, s0);
    pwm_run(10, 5, 30);
    chk("recov_strobe", int'(n_strobe > s0), 1);
    chk("recov_per",  last_per, 10);
    chk("recov_duty", last_duty, 5);

    // 100 % duty: flag lands exactly when the no-edge count reaches 64.
    pwm_in = 1'b1;
    wait_cyc(66);
    chk("high_not_yet", int'(stuck_high), 0);
    wait_cyc(1);
    chk("high_stuck",   int'(stuck_high), 1);
    chk("high_stuck_l", int'(stuck_low), 0);
    chk("high_duty",    int'(duty_tenths), 10);
    chk("high_period",  int'(period), 0);

    // Async reset while a divide is in flight.
    pwm_run(10, 5, 50);
    chk("pre_rst_per", int'(period), 10);
    pwm_in = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_period", int'(period), 0);
    chk("arst_high",   int'(high_time), 0);
    chk("arst_duty",   int'(duty_tenths), 0);
    chk("arst_valid",  int'(meas_valid), 0);
    chk("arst_stuck",  int'(stuck_high | stuck_low), 0);
    wait_cyc(3);
    s0 = n_strobe;
    rst = 1'b0;
    pwm_in = 1'b0;
    wait_cyc(20);
    chk("arst_no_strobe", n_strobe, s0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
